// File: rtl/cpu_pkg.sv
// Shared CPU constants: ARM condition-field encodings and NZCV flag bit positions.
package cpu_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Evaluates a 4-bit condition field against stored NZCV flags; purely combinational.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV register, zero-latency strobe gating, saturating squash count.
// Flags update one cycle after a passing instruction; en=0 stalls all state and forces strobes low.
module cond_logic
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             InstrValid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] SquashCnt
);

  logic go;
  logic squash;

  // Condition is judged against the stored flags only, never this cycle's ALU result.
  cond_check uCondCheck (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  assign go       = en & InstrValid & CondEx;
  assign squash   = en & InstrValid & ~CondEx;
  assign PCSrc    = PCS  & go;
  assign RegWrite = RegW & go;
  assign MemWrite = MemW & go;

  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else if (go) begin
      if (FlagW[1]) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (FlagW[0]) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      SquashCnt <= '0;
    end else if (squash && (SquashCnt != '1)) begin
      SquashCnt <= SquashCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: driver pushes model predictions, monitor pops and compares.
module tb_cond_logic;

  logic        clk;
  logic        reset;
  logic        en;
  logic        InstrValid;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS, RegW, MemW;

  logic        PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]  Flags;
  logic [15:0] SquashCnt;
  logic        satPCSrc, satRegWrite, satMemWrite, satCondEx;
  logic [3:0]  satFlags;
  logic [1:0]  satSquashCnt;

  cond_logic #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .InstrValid(InstrValid), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags), .SquashCnt(SquashCnt)
  );

  cond_logic #(.CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .en(en), .InstrValid(InstrValid), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .PCSrc(satPCSrc), .RegWrite(satRegWrite), .MemWrite(satMemWrite), .CondEx(satCondEx),
    .Flags(satFlags), .SquashCnt(satSquashCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       chk;
    bit       condEx;
    bit       pcSrc;
    bit       regWrite;
    bit       memWrite;
    bit [3:0] flags;
    int       cnt16;
    int       cnt2;
  } exp_t;

  exp_t     expQ[$];
  int       vectors    = 0;
  int       miscompares = 0;
  bit [3:0] mFlags = 4'b0000;
  int       mCnt16 = 0;
  int       mCnt2  = 0;
  bit       mKnown = 1'b0;

  // Architectural meaning: pairs of codes share a predicate; the odd code is its negation.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit iv, input logic [3:0] c,
                      input logic [3:0] af, input logic [1:0] fw,
                      input bit p, input bit rw, input bit mw);
    exp_t x;
    bit   ok, go;
    @(negedge clk);
    reset = r; en = e; InstrValid = iv; Cond = c; ALUFlags = af; FlagW = fw;
    PCS = p; RegW = rw; MemW = mw;
    ok = cond_ok(c, mFlags);
    go = e && iv && ok;
    x.chk = mKnown; x.condEx = ok; x.pcSrc = p && go; x.regWrite = rw && go;
    x.memWrite = mw && go; x.flags = mFlags; x.cnt16 = mCnt16; x.cnt2 = mCnt2;
    expQ.push_back(x);
    if (r) begin
      mFlags = 4'b0000; mCnt16 = 0; mCnt2 = 0; mKnown = 1'b1;
    end else if (e && iv) begin
      if (go) begin
        mFlags = {fw[1] ? af[3:2] : mFlags[3:2], fw[0] ? af[1:0] : mFlags[1:0]};
      end else begin
        if (mCnt16 < 65535) mCnt16++;
        if (mCnt2 < 3) mCnt2++;
      end
    end
  endtask

  task automatic setFlags(input logic [3:0] f);
    step(0, 1, 1, 4'hE, f, 2'b11, 0, 0, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        exp_t x;
        x = expQ.pop_front();
        if (x.chk) begin
          cmp("CondEx",       {15'd0, CondEx},   {15'd0, x.condEx});
          cmp("PCSrc",        {15'd0, PCSrc},    {15'd0, x.pcSrc});
          cmp("RegWrite",     {15'd0, RegWrite}, {15'd0, x.regWrite});
          cmp("MemWrite",     {15'd0, MemWrite}, {15'd0, x.memWrite});
          cmp("Flags",        {12'd0, Flags},    {12'd0, x.flags});
          cmp("SquashCnt",    SquashCnt,         16'(x.cnt16));
          cmp("satFlags",     {12'd0, satFlags}, {12'd0, x.flags});
          cmp("satSquashCnt", {14'd0, satSquashCnt}, 16'(x.cnt2));
          cmp("satCondEx",    {15'd0, satCondEx}, {15'd0, x.condEx});
        end
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; InstrValid = 1'b0; Cond = 4'h0; ALUFlags = 4'h0;
    FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;

    // Reset with random inputs, then AL instruction commits all strobes.
    repeat (2) step(1, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                    2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    step(0, 1, 1, 4'hE, 4'h0, 2'b00, 1, 1, 1);

    // Compare then branch EQ, then NE squashed.
    step(0, 1, 1, 4'hE, 4'b0100, 2'b11, 0, 0, 0);
    step(0, 1, 1, 4'h0, 4'h0, 2'b00, 1, 0, 0);
    step(0, 1, 1, 4'h1, 4'h0, 2'b00, 1, 0, 0);
    step(0, 1, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0);

    // Failed condition blocks flag update.
    step(1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
    step(0, 1, 1, 4'h0, 4'hF, 2'b11, 0, 1, 0);
    step(0, 1, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0);

    // Partial flag writes.
    setFlags(4'b1010);
    step(0, 1, 1, 4'hE, 4'b0101, 2'b01, 0, 0, 0);
    step(0, 1, 1, 4'hE, 4'b0100, 2'b10, 0, 0, 0);
    step(0, 1, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0);

    // Stall, then bubble on a failing condition.
    setFlags(4'b0000);
    step(0, 0, 1, 4'hE, 4'hF, 2'b11, 1, 1, 1);
    step(0, 0, 1, 4'h0, 4'hF, 2'b11, 1, 1, 1);
    step(0, 1, 0, 4'h0, 4'hF, 2'b11, 1, 1, 1);
    step(0, 1, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0);

    // Saturation: five squashes from reset.
    step(1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0);
    repeat (5) step(0, 1, 1, 4'hF, 4'($urandom), 2'b11, 1, 1, 1);
    step(0, 1, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0);

    // Exhaustive condition sweep against every flag value.
    for (int f = 0; f < 16; f++) begin
      setFlags(4'(f));
      for (int c = 0; c < 16; c++) step(0, 1, 1, 4'(c), 4'($urandom), 2'b00, 1, 1, 1);
    end

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 5) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #5;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the instruction decoder in the single-cycle ARM-like CPU.
- Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against the stored flags.
- Gates the decoder's PCS/RegW/MemW into the committed PCSrc/RegWrite/MemWrite strobes.
- Updates flags from the ALU according to the decoder's FlagW, and keeps a saturating count of squashed (condition-failed) instructions for debug.

Parameters:
- CNT_W, 16, width of the squashed-instruction counter SquashCnt (minimum 2).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  stage enable; 0 = stall: no flag or counter update, all strobes forced to 0.
- InstrValid  in  1  current instruction is real (0 = bubble).
- Cond  in  4  condition field, Instr[31:28].
- ALUFlags  in  4  NZCV from the ALU this cycle: [3]=N, [2]=Z, [1]=C, [0]=V.
- FlagW  in  2  from decoder; [1] writes N,Z; [0] writes C,V.
- PCS  in  1  from decoder: instruction writes the PC.
- RegW  in  1  from decoder: instruction writes the register file.
- MemW  in  1  from decoder: instruction writes memory.
- PCSrc  out  1  committed PC write.
- RegWrite  out  1  committed register write.
- MemWrite  out  1  committed memory write.
- CondEx  out  1  condition passed (combinational, from stored Flags).
- Flags  out  4  current stored NZCV.
- SquashCnt  out  CNT_W  saturating count of squashed valid instructions.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge): Flags=4'b0000 and SquashCnt=0. Reset has priority over en and all other inputs. A reset asserted mid-stream discards any pending flag update in that cycle.
- CondEx is combinational on Cond and the stored Flags. It never uses the same-cycle ALUFlags. Condition table (N,Z,C,V are the stored flags):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: reserved, CondEx=0.
- Let go = en & InstrValid & CondEx. Then PCSrc=PCS&go, RegWrite=RegW&go, MemWrite=MemW&go. These are combinational and have zero latency.
- Flag update at the rising edge when go=1:
  - FlagW[1]=1 loads Flags[3:2] from ALUFlags[3:2].
  - FlagW[0]=1 loads Flags[1:0] from ALUFlags[1:0].
  - The two halves are independent; FlagW=2'b00 leaves Flags unchanged.
  - Updated Flags are visible to CondEx from the next cycle (latency 1).
- No flag update when go=0, regardless of FlagW. This covers a failed condition, a stall and a bubble.
- Squash counting: at the rising edge, if en & InstrValid & ~CondEx, SquashCnt increments by 1. It saturates at all-ones and never wraps.
- Stall (en=0): Flags and SquashCnt hold. Strobes are 0. CondEx still reflects Cond vs Flags.
- Back-to-back: a flag-setting instruction followed by a conditional instruction sees the new flags on the following cycle with no bubble required.

Decomposition:
- Shared package (cpu_pkg) holds:
  - condition-code localparams COND_EQ..COND_AL, COND_NV=4'b1111;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - The decoder and test benches reuse these.
- One sub-module, cond_check: purely combinational Cond + Flags -> CondEx.
- cond_logic itself contains the flag register, the gating logic and the counter.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with random inputs -> Flags=0000, SquashCnt=0, and with Cond=1110 (AL), PCS=RegW=MemW=1 gives PCSrc=RegWrite=MemWrite=1.
- Compare then branch: cycle 1 Cond=1110, FlagW=11, ALUFlags=0100. Cycle 2 Cond=0000 (EQ), PCS=1 -> CondEx=1, PCSrc=1, Flags=0100. Cycle 3 with Cond=0001 (NE) -> PCSrc=0, SquashCnt=1.
- Failed condition blocks flags: Flags=0000; Cond=0000, FlagW=11, ALUFlags=1111 -> next cycle Flags still 0000, RegWrite=0, SquashCnt increments.
- Partial write: Flags=1010; Cond=1110, FlagW=01, ALUFlags=0101 -> Flags=1001. Then FlagW=10, ALUFlags=0100 -> Flags=0101.
- Stall and bubble: en=0 with Cond=1110, FlagW=11, ALUFlags=1111 -> Flags unchanged, all strobes 0, SquashCnt unchanged. InstrValid=0 with Cond=0000 while Z=0 -> SquashCnt unchanged.
- Exhaustive condition sweep plus saturation: all 16 Cond values against all 16 Flags values -> CondEx matches the table (1111 always 0). With CNT_W=2, 5 squashes -> SquashCnt=3.
